// File: rtl/ram_access_ctrl.sv
// Two-port load/store controller in front of a byte-addressed RAM with a single 32-bit port.
// Define ARB_ROUND_ROBIN_EN for alternating arbitration on contention; default is fixed priority to port 0.
module ram_access_ctrl #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] ADDR_MAX      = 32'h1FFFC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     p0_valid,
  output logic                     p0_ready,
  input  logic                     p0_we,
  input  logic [1:0]               p0_size,
  input  logic                     p0_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [31:0]              p0_wdata,
  output logic                     p0_rvalid,
  output logic [31:0]              p0_rdata,
  output logic                     p0_err,
  input  logic                     p1_valid,
  output logic                     p1_ready,
  input  logic                     p1_we,
  input  logic [1:0]               p1_size,
  input  logic                     p1_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [31:0]              p1_wdata,
  output logic                     p1_rvalid,
  output logic [31:0]              p1_rdata,
  output logic                     p1_err,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata,
  output logic                     busy
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]               r_state;
  logic                     r_we;
  logic [1:0]               r_size;
  logic                     r_unsigned;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [31:0]              r_wdata;
  logic                     r_port;
  logic                     r_last_grant;
  logic [31:0]              r_ram_wdata;
  logic                     r_p0_rvalid, r_p1_rvalid;
  logic                     r_p0_err, r_p1_err;
  logic [31:0]              r_p0_rdata, r_p1_rdata;

  logic        w_idle, w_access;
  logic        w_grant0, w_grant1, w_any_grant;
  logic        w_last_grant_nxt;
  logic        w_err;
  logic [31:0] w_merged, w_load, w_result;

  // Ready must stay low while reset is held, even with a request pending.
  assign w_idle   = (r_state == S_IDLE) & rst_n;
  assign w_access = (r_state == S_ACCESS);

`ifdef ARB_ROUND_ROBIN_EN
  assign w_grant1 = w_idle & p1_valid & (~p0_valid | ~r_last_grant);
`else
  assign w_grant1 = w_idle & p1_valid & ~p0_valid;
`endif
  assign w_grant0    = w_idle & p0_valid & ~w_grant1;
  assign w_any_grant = w_grant0 | w_grant1;

  assign w_last_grant_nxt = w_any_grant ? w_grant1 : r_last_grant;

  assign w_err = (r_size == 2'b11) | (r_addr > ADDR_MAX);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_merged = r_wdata;
    w_load   = ram_rdata;
    case (r_size)
      2'b00: begin
        w_merged = {ram_rdata[31:8], r_wdata[7:0]};
        w_load   = r_unsigned ? {24'h0, ram_rdata[7:0]} : {{24{ram_rdata[7]}}, ram_rdata[7:0]};
      end
      2'b01: begin
        w_merged = {ram_rdata[31:16], r_wdata[15:0]};
        w_load   = r_unsigned ? {16'h0, ram_rdata[15:0]} : {{16{ram_rdata[15]}}, ram_rdata[15:0]};
      end
      default: begin
        w_merged = r_wdata;
        w_load   = ram_rdata;
      end
    endcase
  end

  assign w_result = (r_we | w_err) ? 32'h0 : w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_port       <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_last_grant <= w_last_grant_nxt;
      if (r_state == S_IDLE) begin
        if (w_any_grant) begin
          r_state    <= S_ACCESS;
          r_port     <= w_grant1;
          r_we       <= w_grant1 ? p1_we       : p0_we;
          r_size     <= w_grant1 ? p1_size     : p0_size;
          r_unsigned <= w_grant1 ? p1_unsigned : p0_unsigned;
          r_addr     <= w_grant1 ? p1_addr     : p0_addr;
          r_wdata    <= w_grant1 ? p1_wdata    : p0_wdata;
        end
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  // Response and write-data hold registers, loaded at the end of the access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_err    <= 1'b0;
      r_p1_err    <= 1'b0;
      r_p0_rdata  <= 32'h0;
      r_p1_rdata  <= 32'h0;
      r_ram_wdata <= 32'h0;
    end else begin
      r_p0_rvalid <= w_access & ~r_port;
      r_p1_rvalid <= w_access & r_port;
      r_p0_err    <= w_access & ~r_port & w_err;
      r_p1_err    <= w_access & r_port & w_err;
      if (w_access & ~r_port) r_p0_rdata <= w_result;
      if (w_access & r_port)  r_p1_rdata <= w_result;
      if (w_access)           r_ram_wdata <= w_merged;
    end
  end

  assign p0_ready  = w_grant0;
  assign p1_ready  = w_grant1;
  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign p0_err    = r_p0_err;
  assign p1_err    = r_p1_err;
  assign ram_we    = w_access & r_we & ~w_err;
  assign ram_addr  = r_addr;
  assign ram_wdata = w_access ? w_merged : r_ram_wdata;
  assign busy      = w_access;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: byte-array RAM, byte-level reference model, directed and random requests.
module tb_ram_access_ctrl;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int MEM_BYTES = 131072;

  logic        clk, rst_n;
  logic        p0_valid, p0_ready, p0_we, p0_unsigned, p0_rvalid, p0_err;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_valid, p1_ready, p1_we, p1_unsigned, p1_rvalid, p1_err;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        ram_we, busy;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  bit [7:0] ram  [MEM_BYTES];
  bit [7:0] mref [MEM_BYTES];
  bit       mdl_last;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_we     = 0;
  int n_rv0    = 0;
  int n_rv1    = 0;

  ram_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_size(p0_size),
    .p0_unsigned(p0_unsigned), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_size(p1_size),
    .p1_unsigned(p1_unsigned), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: 4 bytes starting at the byte address, little-endian.
  logic [16:0] a0;
  assign a0 = ram_addr[16:0];
  assign ram_rdata = {ram[a0 + 17'd3], ram[a0 + 17'd2], ram[a0 + 17'd1], ram[a0]};

  always @(posedge clk) begin
    if (ram_we) begin
      ram[a0]          <= ram_wdata[7:0];
      ram[a0 + 17'd1]  <= ram_wdata[15:8];
      ram[a0 + 17'd2]  <= ram_wdata[23:16];
      ram[a0 + 17'd3]  <= ram_wdata[31:24];
    end
  end

  always @(negedge clk) begin
    if (ram_we)    n_we++;
    if (p0_rvalid) n_rv0++;
    if (p1_rvalid) n_rv1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [16:0] b;
    b = a[16:0];
    return {ram[b + 17'd3], ram[b + 17'd2], ram[b + 17'd1], ram[b]};
  endfunction

  // Reference: touch only the 1/2/4 addressed bytes; loads assemble then extend arithmetically.
  function automatic void model_op(input bit we, input logic [1:0] size, input bit uns,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   output logic [31:0] rd, output bit err);
    int nbytes;
    logic [31:0] v;
    rd  = 32'h0;
    err = (size == 2'b11) || (addr > 32'h1FFFC);
    if (err) return;
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    if (we) begin
      for (int i = 0; i < nbytes; i++) mref[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v[8*i +: 8] = mref[int'(addr) + i];
      if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
      rd = v;
    end
  endfunction

  task automatic idle_inputs();
    p0_valid = 1'b0; p1_valid = 1'b0;
  endtask

  task automatic xfer(input int port, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                      output logic [31:0] obs_rd);
    logic [31:0] exp_rd;
    bit          exp_err, got;
    int          we0;
    model_op(we, size, uns, addr, wdata, exp_rd, exp_err);
    mdl_last = (port != 0);
    we0 = n_we;
    @(negedge clk);
    if (port == 0) begin
      p0_valid = 1'b1; p0_we = we; p0_size = size; p0_unsigned = uns; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_valid = 1'b1; p1_we = we; p1_size = size; p1_unsigned = uns; p1_addr = addr; p1_wdata = wdata;
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if ((port == 0) ? p0_ready : p1_ready) got = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_accept"}, 32'(got), 32'd1);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    obs_rd = (port == 0) ? p0_rdata : p1_rdata;
    check({tag, "_rvalid"}, 32'((port == 0) ? p0_rvalid : p1_rvalid), 32'd1);
    check({tag, "_other_rvalid"}, 32'((port == 0) ? p1_rvalid : p0_rvalid), 32'd0);
    check({tag, "_rdata"}, obs_rd, exp_rd);
    check({tag, "_err"}, 32'((port == 0) ? p0_err : p1_err), 32'(exp_err));
    check({tag, "_we_cycles"}, 32'(n_we - we0), 32'((we && !exp_err) ? 1 : 0));
  endtask

  initial begin
    logic [31:0] rd, a;
    bit          grants [4];
    bit          exp_g;
    int          ng, rv0_start, rv1_start, exp0, exp1, mism;
    bit          we;
    logic [1:0]  sz;
    int          sel;

    rst_n = 1'b1;
    p0_valid = 1'b0; p0_we = 1'b0; p0_size = 2'b00; p0_unsigned = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_size = 2'b00; p1_unsigned = 1'b0; p1_addr = '0; p1_wdata = '0;
    mdl_last = 1'b1;
    #2 rst_n = 1'b0;
    p0_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_p0_ready", 32'(p0_ready), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    p0_valid = 1'b0;
    rst_n = 1'b1;

    // Directed word / byte / half sequence
    xfer(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, "st_w", rd);
    xfer(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "ld_w", rd);
    check("ld_w_value", rd, 32'hDEADBEEF);
    @(negedge clk);
    check("ld_w_pulse_end", 32'(p0_rvalid), 32'd0);
    xfer(0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000007F, "st_b", rd);
    xfer(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "ld_w2", rd);
    check("merge_value", rd, 32'hDEAD7FEF);
    xfer(0, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, "ld_b_s", rd);
    check("ld_b_s_value", rd, 32'h0000007F);
    xfer(0, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, "ld_h_s", rd);
    check("ld_h_s_value", rd, 32'h00007FEF);
    xfer(0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h00000080, "st_b80", rd);
    xfer(0, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, "ld_b_neg", rd);
    check("ld_b_neg_value", rd, 32'hFFFFFF80);
    xfer(0, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, "ld_b_u", rd);
    check("ld_b_u_value", rd, 32'h00000080);

    // Contention: both ports request every cycle for four grants
    @(negedge clk);
    p0_valid = 1'b1; p0_we = 1'b0; p0_size = 2'b10; p0_unsigned = 1'b0; p0_addr = 32'h100;
    p1_valid = 1'b1; p1_we = 1'b0; p1_size = 2'b10; p1_unsigned = 1'b0; p1_addr = 32'h104;
    rv0_start = n_rv0; rv1_start = n_rv1; ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (p0_ready) begin grants[ng] = 1'b0; ng++; end
      else if (p1_ready) begin grants[ng] = 1'b1; ng++; end
      @(negedge clk);
    end
    idle_inputs();
    check("arb_grant_count", 32'(ng), 32'd4);
    exp0 = 0; exp1 = 0;
    for (int g = 0; g < 4; g++) begin
      exp_g = RR ? ~mdl_last : 1'b0;
      mdl_last = exp_g;
      if (exp_g) exp1++; else exp0++;
      check($sformatf("arb_grant%0d", g), 32'(grants[g]), 32'(exp_g));
    end
    repeat (3) @(negedge clk);
    check("arb_p0_rvalids", 32'(n_rv0 - rv0_start), 32'(exp0));
    check("arb_p1_rvalids", 32'(n_rv1 - rv1_start), 32'(exp1));

    // Error responses on port 1
    xfer(1, 1'b0, 2'b00, 1'b0, 32'h1FFFD, 32'h0, "err_addr", rd);
    check("err_addr_rdata", rd, 32'h0);
    xfer(1, 1'b1, 2'b11, 1'b0, 32'h100, 32'h11223344, "err_size", rd);
    check("err_size_mem", ram_word(32'h100), 32'hDEAD80EF);
    xfer(1, 1'b0, 2'b10, 1'b1, 32'h1FFFC, 32'h0, "edge_ok", rd);

    // Reset in the middle of a store access
    xfer(0, 1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D, "st_pre", rd);
    @(negedge clk);
    p0_valid = 1'b1; p0_we = 1'b1; p0_size = 2'b10; p0_addr = 32'h200; p0_wdata = 32'h12345678;
    #1;
    check("abort_accept", 32'(p0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("abort_we_before", 32'(ram_we), 32'd1);
    rv0_start = n_rv0;
    rst_n = 1'b0;
    p0_valid = 1'b0;
    #1;
    check("abort_we_dropped", 32'(ram_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mdl_last = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_rvalid", 32'(n_rv0 - rv0_start), 32'd0);
    check("abort_mem", ram_word(32'h200), 32'hCAFEF00D);

    // Random traffic against the byte-level model
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      sz  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = 32'h300 + $urandom_range(0, 63);
      else if (sel < 9) a = 32'h1FFF8 + $urandom_range(0, 7);
      else              a = $urandom;
      xfer(int'($urandom_range(0, 1)), we, sz, 1'($urandom_range(0, 1)), a, $urandom,
           $sformatf("rnd%0d", i), rd);
    end

    mism = 0;
    for (int b = 32'h300; b < 32'h344; b++) if (ram[b] != mref[b]) mism++;
    for (int b = 32'h1FFF8; b < MEM_BYTES; b++) if (ram[b] != mref[b]) mism++;
    check("mem_compare", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
